// File: rtl/rob_alloc_ctrl_pkg.sv
// rob_alloc_ctrl_pkg
//   Shared ROB constants and types for the reorder-buffer allocator slice.
//   ROB_ADDR_WIDTH_DEF : default log2 of ROB depth
//   WB_PORTS_DEF       : default number of execution-unit writeback ports
//   rob_state_e        : allocator control state (RUN / RECOVER)
package rob_alloc_ctrl_pkg;

    localparam int unsigned ROB_ADDR_WIDTH_DEF = 4;
    localparam int unsigned WB_PORTS_DEF       = 2;

    typedef enum logic {
        ROB_ST_RUN     = 1'b0,
        ROB_ST_RECOVER = 1'b1
    } rob_state_e;

endpackage

// File: rtl/rob_alloc_ctrl_status_array.sv
// rob_status_array
//   Per-entry busy/done/exception bit vectors of the reorder buffer.
//   Ports:
//     clk, rst       : clock, synchronous active-low reset
//     clear_all      : wipe every entry (flush); overrides all other updates
//     alloc_en/tag   : mark entry busy, not done, no exception
//     wb_en/tag/exc  : per-port writeback; only affects entries already busy
//     commit_en/tag  : retire entry (clear all three bits)
//     busy/done/exc  : registered status vectors, one bit per entry
module rob_status_array
    import rob_alloc_ctrl_pkg::*;
#(
    parameter int unsigned ROB_ADDR_WIDTH = ROB_ADDR_WIDTH_DEF,
    parameter int unsigned WB_PORTS       = WB_PORTS_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clear_all,
    input  logic                               alloc_en,
    input  logic [ROB_ADDR_WIDTH-1:0]          alloc_tag,
    input  logic [WB_PORTS-1:0]                wb_en,
    input  logic [WB_PORTS*ROB_ADDR_WIDTH-1:0] wb_tag,
    input  logic [WB_PORTS-1:0]                wb_exc,
    input  logic                               commit_en,
    input  logic [ROB_ADDR_WIDTH-1:0]          commit_tag,
    output logic [(1<<ROB_ADDR_WIDTH)-1:0]     busy,
    output logic [(1<<ROB_ADDR_WIDTH)-1:0]     done,
    output logic [(1<<ROB_ADDR_WIDTH)-1:0]     exc
);

    localparam int unsigned DEPTH = 1 << ROB_ADDR_WIDTH;

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [DEPTH-1:0] done_q, done_d;
    logic [DEPTH-1:0] exc_q,  exc_d;

    // Update order: writeback, then allocate, then commit, then flush.
    // Writeback qualifies on the registered busy bit, so a strobe to an
    // entry being allocated this same cycle is dropped.
    always_comb begin
        busy_d = busy_q;
        done_d = done_q;
        exc_d  = exc_q;
        for (int unsigned p = 0; p < WB_PORTS; p++) begin
            if (wb_en[p] && busy_q[wb_tag[p*ROB_ADDR_WIDTH +: ROB_ADDR_WIDTH]]) begin
                done_d[wb_tag[p*ROB_ADDR_WIDTH +: ROB_ADDR_WIDTH]] = 1'b1;
                exc_d[wb_tag[p*ROB_ADDR_WIDTH +: ROB_ADDR_WIDTH]] =
                    exc_d[wb_tag[p*ROB_ADDR_WIDTH +: ROB_ADDR_WIDTH]] | wb_exc[p];
            end
        end
        if (alloc_en) begin
            busy_d[alloc_tag] = 1'b1;
            done_d[alloc_tag] = 1'b0;
            exc_d[alloc_tag]  = 1'b0;
        end
        if (commit_en) begin
            busy_d[commit_tag] = 1'b0;
            done_d[commit_tag] = 1'b0;
            exc_d[commit_tag]  = 1'b0;
        end
        if (clear_all) begin
            busy_d = '0;
            done_d = '0;
            exc_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
            done_q <= '0;
            exc_q  <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            exc_q  <= exc_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign exc  = exc_q;

endmodule

// File: rtl/rob_alloc_ctrl.sv
// rob_alloc_ctrl
//   ROB tag allocator and in-order commit sequencer.
//   Ports:
//     clk, rst            : clock, synchronous active-low reset
//     flush               : pipeline flush, top priority, empties the ROB
//     alloc_valid/ready   : dispatch handshake; alloc_tag is the current tail
//     stall_req           : alloc_valid && !alloc_ready
//     wb_en/wb_tag/wb_exc : per-port writeback (port p tag at [p*W +: W])
//     commit_valid/tag/exc: oldest entry ready to retire; commit_ack consumes
//     rob_empty/rob_count : occupancy
module rob_alloc_ctrl
    import rob_alloc_ctrl_pkg::*;
#(
    parameter int unsigned ROB_ADDR_WIDTH = ROB_ADDR_WIDTH_DEF,
    parameter int unsigned WB_PORTS       = WB_PORTS_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic                               alloc_valid,
    output logic                               alloc_ready,
    output logic [ROB_ADDR_WIDTH-1:0]          alloc_tag,
    output logic                               stall_req,
    input  logic [WB_PORTS-1:0]                wb_en,
    input  logic [WB_PORTS*ROB_ADDR_WIDTH-1:0] wb_tag,
    input  logic [WB_PORTS-1:0]                wb_exc,
    output logic                               commit_valid,
    output logic [ROB_ADDR_WIDTH-1:0]          commit_tag,
    output logic                               commit_exc,
    input  logic                               commit_ack,
    output logic                               rob_empty,
    output logic [ROB_ADDR_WIDTH:0]            rob_count
);

    localparam int unsigned DEPTH = 1 << ROB_ADDR_WIDTH;
    localparam logic [ROB_ADDR_WIDTH:0] DEPTH_CNT = (ROB_ADDR_WIDTH+1)'(DEPTH);

    rob_state_e                state_q, state_d;
    logic [ROB_ADDR_WIDTH-1:0] head_q,  head_d;
    logic [ROB_ADDR_WIDTH-1:0] tail_q,  tail_d;
    logic [ROB_ADDR_WIDTH:0]   count_q, count_d;

    logic [DEPTH-1:0] busy, done, exc;
    logic             alloc_fire, commit_fire;

    // Gated by rst so nothing is offered while reset is held; full is
    // judged on registered count, so a same-cycle commit frees nothing.
    assign alloc_ready  = rst && (state_q == ROB_ST_RUN) && !flush && (count_q < DEPTH_CNT);
    assign stall_req    = rst && alloc_valid && !alloc_ready;
    assign alloc_tag    = tail_q;
    assign alloc_fire   = alloc_valid && alloc_ready;

    assign commit_valid = busy[head_q] && done[head_q];
    assign commit_tag   = head_q;
    assign commit_exc   = exc[head_q];
    assign commit_fire  = commit_ack && commit_valid && !flush;

    assign rob_empty    = (count_q == '0);
    assign rob_count    = count_q;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            state_d = ROB_ST_RECOVER;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (state_q == ROB_ST_RECOVER) begin
                state_d = ROB_ST_RUN;
            end
            if (alloc_fire) begin
                tail_d = tail_q + ROB_ADDR_WIDTH'(1);
            end
            if (commit_fire) begin
                head_d = head_q + ROB_ADDR_WIDTH'(1);
            end
            case ({alloc_fire, commit_fire})
                2'b10:   count_d = count_q + (ROB_ADDR_WIDTH+1)'(1);
                2'b01:   count_d = count_q - (ROB_ADDR_WIDTH+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ROB_ST_RUN;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    rob_status_array #(
        .ROB_ADDR_WIDTH (ROB_ADDR_WIDTH),
        .WB_PORTS       (WB_PORTS)
    ) u_status (
        .clk        (clk),
        .rst        (rst),
        .clear_all  (flush),
        .alloc_en   (alloc_fire),
        .alloc_tag  (tail_q),
        .wb_en      (wb_en),
        .wb_tag     (wb_tag),
        .wb_exc     (wb_exc),
        .commit_en  (commit_fire),
        .commit_tag (head_q),
        .busy       (busy),
        .done       (done),
        .exc        (exc)
    );

endmodule

// File: doc/rob_alloc_ctrl.md
Name: rob_alloc_ctrl

Overview:
- Reorder-buffer entry allocator and commit sequencer sitting between IDROB and the ROB/commit stage.
- Hands each decoded instruction a ROB tag and tracks per-entry busy/done/exception status as execution units write back.
- Presents the oldest completed entry for in-order commit.
- Raises a stall towards ID/IDROB when the ROB is full or recovering from a flush.

Parameters:
ROB_ADDR_WIDTH, 4, log2 of ROB depth (depth = 2^ROB_ADDR_WIDTH = 16)
WB_PORTS, 2, number of independent writeback ports from execution units

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-low
flush  in  1  pipeline flush (branch mispredict / exception)
alloc_valid  in  1  IDROB holds a valid decoded instruction to dispatch
alloc_ready  out  1  allocation accepted this cycle
alloc_tag  out  ROB_ADDR_WIDTH  tag assigned to the instruction (current tail)
stall_req  out  1  stall ID/IDROB (alloc_valid && !alloc_ready)
wb_en  in  WB_PORTS  per-port writeback strobe
wb_tag  in  WB_PORTS*ROB_ADDR_WIDTH  per-port tag, port p at bits [p*W +: W]
wb_exc  in  WB_PORTS  per-port "entry raised exception"
commit_valid  out  1  head entry busy and done
commit_tag  out  ROB_ADDR_WIDTH  head pointer
commit_exc  out  1  head entry exception flag
commit_ack  in  1  commit stage consumed head entry
rob_empty  out  1  count == 0
rob_count  out  ROB_ADDR_WIDTH+1  number of busy entries

Behaviour:
- Reset (rst == 0 at posedge clk):
  - head, tail and count cleared; busy/done/exc vectors cleared; state = RUN.
  - Outputs: alloc_ready=0, stall_req=0, commit_valid=0, alloc_tag=0, commit_tag=0, commit_exc=0, rob_empty=1, rob_count=0.
- States: RUN, RECOVER.
  - RUN -> RECOVER on flush.
  - RECOVER -> RUN unconditionally after one cycle.
  - flush while in RECOVER stays RECOVER one more cycle.
- flush has top priority:
  - Next cycle head=tail=count=0 and all busy/done/exc bits cleared.
  - Same-cycle alloc, writeback and commit_ack are ignored.
- alloc_ready = (state==RUN) && !flush && (count < 2^ROB_ADDR_WIDTH). It is combinational from registered state only.
- Full is evaluated on registered count: a same-cycle commit does not free a slot for a same-cycle allocation.
- On alloc_valid && alloc_ready:
  - busy[tail]=1, done[tail]=0, exc[tail]=0.
  - tail increments modulo depth (natural wrap of ROB_ADDR_WIDTH bits).
- Writeback: for each p with wb_en[p] and busy[wb_tag_p]=1, set done=1 and exc |= wb_exc[p].
  - Writeback to a non-busy tag is ignored.
  - Two ports hitting the same tag in one cycle: done=1, exc = OR of both.
- commit_valid = busy[head] && done[head] (combinational from registers). commit_tag = head, commit_exc = exc[head].
- On commit_ack && commit_valid:
  - busy/done/exc[head] cleared.
  - head increments modulo depth.
  - commit_ack without commit_valid is ignored.
- Writeback completes in the cycle after strobe: an entry written back in cycle N can commit at cycle N+1 at the earliest.
- count update: +1 on allocation, -1 on commit, unchanged when both or neither happen. count never exceeds depth or underflows.
- rob_empty = (count==0). A wrapped head==tail with count==depth is full, not empty.

Decomposition:
- Shared header (alongside bus.v), holding the ROB constants:
  - ROB_ADDR_WIDTH default.
  - ROB_ADDR_BUS / ROB_COUNT_BUS range macros.
  - State encodings ROB_ST_RUN=1'b0, ROB_ST_RECOVER=1'b1.
- One sub-module rob_status_array: holds the busy/done/exc bit vectors, with set-on-alloc, set-on-writeback (WB_PORTS ports), clear-on-commit and clear-all.
- Pointer, count and state logic stay in rob_alloc_ctrl.

Test Plan:
- Reset then 3 allocs with alloc_valid=1 -> alloc_tag 0,1,2 on successive cycles, rob_count=3, commit_valid=0.
- wb_en=01 tag 1, then wb_en=01 tag 0 -> commit_valid rises only after tag 0 done. commit_ack commits tag 0, then tag 1 the next cycle; tag 2 holds commit_valid=0.
- Fill 16 entries, keep alloc_valid=1 -> alloc_ready=0, stall_req=1, rob_count=16, rob_empty=0. Assert commit_ack on a done head in the same cycle -> still no alloc that cycle; alloc resumes next cycle with alloc_tag=0 (wrap).
- Both ports write back tag 5 with wb_exc=10 -> head reaching 5 shows commit_valid=1, commit_exc=1.
- flush with 7 entries busy, alloc_valid=1 and commit_ack=1 -> next cycle rob_count=0, rob_empty=1, alloc_ready=0 (RECOVER). The following cycle alloc_ready=1 with alloc_tag=0.
- Writeback to a non-busy tag 9 on an empty ROB, then allocate through tag 9 -> entry 9 is not done (commit_valid=0 at head 9 until its own writeback).
